// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dff_ar.sv
// WIDTH-bit D register, rising-edge clocked, asynchronous active-low clear.
module dff_ar #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload terminal-count pulse.
// Edge priority is load > stop > start > decrement.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]   count_d, count_q;
    logic [WIDTH-1:0]   reload_d, reload_q;
    logic [STATE_W-1:0] state_raw_q;
    state_t             state_d, state_q;
    logic               tc_d, tc_q;

    assign state_q = state_t'(state_raw_q);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        tc_d     = 1'b0;

        if (load_i) begin
            count_d  = load_value_i;
            reload_d = load_value_i;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A zero count has nothing to time, so start is ignored.
                    if (start_i && !stop_i && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                    end else if (en_i) begin
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload_i) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    dff_ar #(.WIDTH(WIDTH)) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    dff_ar #(.WIDTH(WIDTH)) u_reload_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (reload_d),
        .q_o   (reload_q)
    );

    dff_ar #(.WIDTH(STATE_W)) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (state_d),
        .q_o   (state_raw_q)
    );

    dff_ar #(.WIDTH(1)) u_tc_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (tc_d),
        .q_o   (tc_q)
    );

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);

endmodule
